// File: rtl/cfa_pkg.sv
// Shared CFA definitions: channel symbol codes, writer FSM encodings
// and the (pattern, row parity, col parity) -> channel decode.
package cfa_pkg;

    localparam logic [1:0] SYM_GREEN = 2'b01;
    localparam logic [1:0] SYM_RED   = 2'b10;
    localparam logic [1:0] SYM_BLUE  = 2'b11;

    localparam logic [1:0] PAT_RGGB = 2'b00;
    localparam logic [1:0] PAT_GRBG = 2'b01;
    localparam logic [1:0] PAT_GBRG = 2'b10;
    localparam logic [1:0] PAT_BGGR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Green sits on the checkerboard whose phase flips for GRBG/GBRG;
    // the remaining sites are red on the row whose parity is pat[1].
    function automatic logic [1:0] cfa_symbol(
        input logic [1:0] pat,
        input logic       row0,
        input logic       col0
    );
        logic green;
        logic red;
        green = (pat[1] ^ pat[0]) ^ (row0 ^ col0);
        red   = (row0 == pat[1]);
        if (green)
            cfa_symbol = SYM_GREEN;
        else if (red)
            cfa_symbol = SYM_RED;
        else
            cfa_symbol = SYM_BLUE;
    endfunction

endpackage

// File: rtl/bayer_mosaic_writer_if.sv
// Plane-read / raw-write memory bus of the Bayer mosaic writer.
// master = writer side, slave = memory side.
interface bayer_mosaic_writer_if #(
    parameter int AW = 17,
    parameter int DW = 12
);
    logic [AW-1:0] readAddress;
    logic          readEnable;
    logic [DW-1:0] greenRead;
    logic [DW-1:0] redRead;
    logic [DW-1:0] blueRead;
    logic [DW-1:0] rawWrite;
    logic [AW-1:0] writeAddress;
    logic          writeEnable;

    modport master (
        output readAddress,
        output readEnable,
        input  greenRead,
        input  redRead,
        input  blueRead,
        output rawWrite,
        output writeAddress,
        output writeEnable
    );

    modport slave (
        input  readAddress,
        input  readEnable,
        output greenRead,
        output redRead,
        output blueRead,
        input  rawWrite,
        input  writeAddress,
        input  writeEnable
    );
endinterface

// File: rtl/bayer_raster_counter.sv
// Raster row/col/linear-address counter with clear, stall and
// last-pixel flag; the address is counted, never multiplied.
module bayer_raster_counter #(
    parameter int RW = 11,
    parameter int CW = 11,
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clear_i,
    input  logic [RW-1:0] row_max_i,
    input  logic [CW-1:0] col_max_i,
    output logic          row_lsb_o,
    output logic          col_lsb_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          col_wrap;

    assign col_wrap = (col_q == col_max_i);

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear_i) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            addr_d = addr_q + 1'b1;
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign row_lsb_o = row_q[0];
    assign col_lsb_o = col_q[0];
    assign addr_o    = addr_q;
    assign last_o    = col_wrap && (row_q == row_max_i);

endmodule

// File: rtl/bayer_mosaic_writer.sv
// Re-mosaics G/R/B planes into a Bayer raw frame with black-level
// offset and saturation; read -> P1 (mem data) -> S1 -> S2 -> write.
module bayer_mosaic_writer
    import cfa_pkg::*;
#(
    parameter int addressBitWidth = 17,
    parameter int rowBitWidth     = 11,
    parameter int colBitWidth     = 11,
    parameter int dataBitWidth    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    en,
    input  logic [rowBitWidth-1:0]  rowMax,
    input  logic [colBitWidth-1:0]  colMax,
    input  logic [1:0]              patternSelect,
    input  logic [dataBitWidth-1:0] blackLevel,
    output logic                    busy,
    output logic                    done,
    bayer_mosaic_writer_if.master   mem
);
    localparam int AW = addressBitWidth;
    localparam int DW = dataBitWidth;

    logic [1:0]             state_q, state_d;
    logic [rowBitWidth-1:0] row_max_q;
    logic [colBitWidth-1:0] col_max_q;
    logic [1:0]             pat_q;
    logic [DW-1:0]          black_q;

    logic          accept, issue, cnt_en;
    logic          cnt_row0, cnt_col0, cnt_last;
    logic [AW-1:0] cnt_addr;
    logic [1:0]    sym;

    logic          p1_vld_q;
    logic [AW-1:0] p1_addr_q;
    logic [1:0]    p1_sym_q;
    logic          hold_q;
    logic [DW-1:0] hold_data_q;
    logic [DW-1:0] mem_sel, p1_data;

    logic          s1_vld_q;
    logic [AW-1:0] s1_addr_q;
    logic [DW-1:0] s1_data_q;
    logic [DW:0]   sum;
    logic [DW-1:0] sat;

    logic          wr_vld_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    assign accept = (state_q == ST_IDLE) && start;
    assign issue  = (state_q == ST_RUN);
    assign cnt_en = issue && en && !cnt_last;

    bayer_raster_counter #(
        .RW(rowBitWidth),
        .CW(colBitWidth),
        .AW(AW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (cnt_en),
        .clear_i  (accept),
        .row_max_i(row_max_q),
        .col_max_i(col_max_q),
        .row_lsb_o(cnt_row0),
        .col_lsb_o(cnt_col0),
        .addr_o   (cnt_addr),
        .last_o   (cnt_last)
    );

    assign sym = cfa_symbol(pat_q, cnt_row0, cnt_col0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (en && cnt_last) state_d = ST_DRAIN;
            ST_DRAIN: if (en && !p1_vld_q && !s1_vld_q)
                          state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unique case (p1_sym_q)
            SYM_RED:  mem_sel = mem.redRead;
            SYM_BLUE: mem_sel = mem.blueRead;
            default:  mem_sel = mem.greenRead;
        endcase
    end

    // Memory data belongs to the address of the previous cycle, so a
    // stall must freeze it here before the held address replaces it.
    assign p1_data = hold_q ? hold_data_q : mem_sel;

    assign sum = {1'b0, s1_data_q} + {1'b0, black_q};
    assign sat = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_max_q   <= '0;
            col_max_q   <= '0;
            pat_q       <= '0;
            black_q     <= '0;
            p1_vld_q    <= 1'b0;
            p1_addr_q   <= '0;
            p1_sym_q    <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                row_max_q <= rowMax;
                col_max_q <= colMax;
                pat_q     <= patternSelect;
                black_q   <= blackLevel;
            end
            if (en) begin
                hold_q <= 1'b0;
            end else if (!hold_q) begin
                hold_q      <= 1'b1;
                hold_data_q <= mem_sel;
            end
            if (en) begin
                p1_vld_q  <= issue;
                p1_addr_q <= cnt_addr;
                p1_sym_q  <= sym;
                s1_vld_q  <= p1_vld_q;
                s1_addr_q <= p1_addr_q;
                s1_data_q <= p1_data;
                wr_vld_q  <= s1_vld_q;
                if (s1_vld_q) begin
                    wr_addr_q <= s1_addr_q;
                    wr_data_q <= sat;
                end
            end
        end
    end

    assign mem.readAddress  = cnt_addr;
    assign mem.readEnable   = issue && en;
    assign mem.rawWrite     = wr_data_q;
    assign mem.writeAddress = wr_addr_q;
    assign mem.writeEnable  = wr_vld_q && en;

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

endmodule
